// File: rtl/usr_shift_ctrl.sv
// usr_shift_ctrl: command sequencer for a 4-bit universal shift register.
// It takes one command at a time (load, shift right, shift left or rotate
// right) and drives the register's select and data inputs cycle by cycle.
module usr_shift_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             ser_in_valid,
  input  logic             ser_in,
  output logic             ser_in_ready,
  input  logic [WIDTH-1:0] usr_q,
  output logic [1:0]       usr_select,
  output logic [WIDTH-1:0] usr_parallel_in,
  output logic             usr_serial_rightin,
  output logic             usr_serial_leftin,
  output logic             done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] OP_LOAD = 2'd0;
  localparam logic [1:0] OP_SHR  = 2'd1;
  localparam logic [1:0] OP_SHL  = 2'd2;
  localparam logic [1:0] OP_ROR  = 2'd3;

  localparam logic [1:0] SEL_HOLD  = 2'd0;
  localparam logic [1:0] SEL_RIGHT = 2'd1;
  localparam logic [1:0] SEL_LEFT  = 2'd2;
  localparam logic [1:0] SEL_LOAD  = 2'd3;

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_reg;
  logic [1:0]       op_reg;
  logic [CNT_W-1:0] remaining_reg;
  logic [WIDTH-1:0] data_reg;
  logic             step_fire;

  // Only bit 0 of the register is needed (rotate feedback).
  logic unused_q_bits;
  assign unused_q_bits = ^usr_q[WIDTH-1:1];

  // A shift step happens every SHIFT cycle for rotate, and only when a
  // serial bit is offered for the shifts that consume the stream.
  assign step_fire = (state_reg == ST_SHIFT) && ((op_reg == OP_ROR) || ser_in_valid);

  // Sequencer state and latched command fields.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      state_reg     <= ST_IDLE;
      op_reg        <= OP_LOAD;
      remaining_reg <= CNT_ZERO;
      data_reg      <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (cmd_valid) begin
            op_reg        <= cmd_op;
            remaining_reg <= cmd_count;
            data_reg      <= cmd_data;
            if (cmd_op == OP_LOAD)
              state_reg <= ST_LOAD;
            else if (cmd_count == CNT_ZERO)
              state_reg <= ST_DONE;
            else
              state_reg <= ST_SHIFT;
          end
        end
        ST_LOAD: state_reg <= ST_DONE;
        ST_SHIFT: begin
          if (step_fire) begin
            remaining_reg <= remaining_reg - CNT_ONE;
            if (remaining_reg == CNT_ONE)
              state_reg <= ST_DONE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign usr_parallel_in = data_reg;

  // Output decode from state and latched fields.
  always_comb begin
    cmd_ready          = 1'b0;
    ser_in_ready       = 1'b0;
    usr_select         = SEL_HOLD;
    usr_serial_rightin = 1'b0;
    usr_serial_leftin  = 1'b0;
    done               = 1'b0;
    case (state_reg)
      ST_IDLE: cmd_ready = 1'b1;
      ST_LOAD: usr_select = SEL_LOAD;
      ST_SHIFT: begin
        case (op_reg)
          OP_SHR: begin
            ser_in_ready = 1'b1;
            if (ser_in_valid) begin
              usr_select         = SEL_RIGHT;
              usr_serial_rightin = ser_in;
            end
          end
          OP_SHL: begin
            ser_in_ready = 1'b1;
            if (ser_in_valid) begin
              usr_select        = SEL_LEFT;
              usr_serial_leftin = ser_in;
            end
          end
          OP_ROR: begin
            usr_select         = SEL_RIGHT;
            usr_serial_rightin = usr_q[0];
          end
          default: usr_select = SEL_HOLD;
        endcase
      end
      ST_DONE: done = 1'b1;
      default: cmd_ready = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_usr_shift_ctrl.sv
// Bench for usr_shift_ctrl: a behavioural universal shift register closes the
// loop, and each command's effect is predicted from plain shift arithmetic.
module tb_usr_shift_ctrl;

  logic       clk = 1'b0;
  logic       rstN;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [2:0] cmd_count;
  logic [3:0] cmd_data;
  logic       ser_in_valid;
  logic       ser_in;
  logic       ser_in_ready;
  logic [3:0] usr_q;
  logic [1:0] usr_select;
  logic [3:0] usr_parallel_in;
  logic       usr_serial_rightin;
  logic       usr_serial_leftin;
  logic       done;

  int checks = 0;
  int errors = 0;
  logic [3:0] model_q;

  always #5 clk = ~clk;

  usr_shift_ctrl #(.WIDTH(4), .CNT_W(3)) dut (
    .clk(clk), .rstN(rstN),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_count(cmd_count), .cmd_data(cmd_data),
    .ser_in_valid(ser_in_valid), .ser_in(ser_in), .ser_in_ready(ser_in_ready),
    .usr_q(usr_q), .usr_select(usr_select), .usr_parallel_in(usr_parallel_in),
    .usr_serial_rightin(usr_serial_rightin), .usr_serial_leftin(usr_serial_leftin),
    .done(done)
  );

  // Controlled universal shift register.
  always_ff @(posedge clk) begin
    if (!rstN) usr_q <= 4'h0;
    else begin
      case (usr_select)
        2'd1: usr_q <= {usr_serial_rightin, usr_q[3:1]};
        2'd2: usr_q <= {usr_q[2:0], usr_serial_leftin};
        2'd3: usr_q <= usr_parallel_in;
        default: usr_q <= usr_q;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one command and follow it to completion. Bits are taken from
  // 'bits' (LSB first) when fixed_bits is set, otherwise random.
  task automatic run_cmd(input logic [1:0] op, input int cnt, input logic [3:0] dat,
                         input int stall_pct, input logic [6:0] bits, input bit fixed_bits);
    int   steps;
    int   idx;
    int   cycles;
    bit   load_pending;
    bit   finished;
    logic v;
    logic b;
    @(negedge clk);
    chk("idle_cmd_ready", cmd_ready, 1);
    chk("idle_done", done, 0);
    cmd_valid    = 1'b1;
    cmd_op       = op;
    cmd_count    = cnt[2:0];
    cmd_data     = dat;
    ser_in_valid = 1'b0;
    #1;
    chk("idle_select", usr_select, 0);
    steps        = (op == 2'd0) ? 0 : cnt;
    load_pending = (op == 2'd0);
    idx          = 0;
    cycles       = 0;
    finished     = 1'b0;
    for (int k = 0; k < 200 && !finished; k++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      cycles++;
      if (load_pending) begin
        ser_in_valid = 1'b0;
        #1;
        chk("load_select", usr_select, 3);
        chk("load_pin", usr_parallel_in, dat);
        chk("load_done_low", done, 0);
        model_q      = dat;
        load_pending = 1'b0;
      end else if (steps > 0) begin
        v = ($urandom_range(99) >= stall_pct) ? 1'b1 : 1'b0;
        b = fixed_bits ? bits[idx] : 1'($urandom_range(1));
        ser_in_valid = (op == 2'd3) ? 1'($urandom_range(1)) : v;
        ser_in       = b;
        #1;
        chk("shift_done_low", done, 0);
        chk("shift_cmd_ready", cmd_ready, 0);
        chk("shift_ser_ready", ser_in_ready, (op != 2'd3) ? 1 : 0);
        if (op == 2'd3) begin
          chk("ror_select", usr_select, 1);
          chk("ror_rightin", usr_serial_rightin, model_q[0]);
          model_q = (model_q >> 1) | (4'(model_q[0]) << 3);
          steps--;
        end else if (v) begin
          if (op == 2'd1) begin
            chk("shr_select", usr_select, 1);
            chk("shr_rightin", usr_serial_rightin, b);
            chk("shr_leftin", usr_serial_leftin, 0);
            model_q = (model_q >> 1) | (4'(b) << 3);
          end else begin
            chk("shl_select", usr_select, 2);
            chk("shl_leftin", usr_serial_leftin, b);
            chk("shl_rightin", usr_serial_rightin, 0);
            model_q = (model_q << 1) | 4'(b);
          end
          steps--;
          idx++;
        end else begin
          chk("stall_select", usr_select, 0);
        end
      end else begin
        ser_in_valid = 1'b0;
        #1;
        chk("done_pulse", done, 1);
        chk("done_select", usr_select, 0);
        chk("done_cmd_ready", cmd_ready, 0);
        chk("result_q", usr_q, model_q);
        finished = 1'b1;
      end
    end
    if (!finished) chk("cmd_timeout", 0, 1);
    $display("cmd op=%0d count=%0d data=%h cycles=%0d q=%h expected=%h",
             op, cnt, dat, cycles, usr_q, model_q);
  endtask

  initial begin
    rstN = 1'b0; cmd_valid = 1'b1; cmd_op = 2'd0; cmd_count = 3'd0; cmd_data = 4'hF;
    ser_in_valid = 1'b0; ser_in = 1'b0; model_q = 4'h0;

    // Reset with a pending LOAD: nothing may be accepted.
    repeat (3) begin
      @(negedge clk);
      chk("rst_select", usr_select, 0);
      chk("rst_done", done, 0);
      chk("rst_pin", usr_parallel_in, 0);
      chk("rst_ser_ready", ser_in_ready, 0);
    end
    cmd_valid = 1'b0;
    rstN      = 1'b1;
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_release_select", usr_select, 0);
    $display("reset done select=%0d cmd_ready=%0d", usr_select, cmd_ready);

    // Directed scenarios.
    run_cmd(2'd0, 0, 4'hA, 0, 7'b0, 1'b1);
    run_cmd(2'd0, 0, 4'h0, 0, 7'b0, 1'b1);
    run_cmd(2'd1, 3, 4'h0, 0, 7'b101, 1'b1);
    chk("shr_example", usr_q, 4'hA);
    run_cmd(2'd2, 2, 4'h0, 60, 7'b11, 1'b1);
    run_cmd(2'd0, 0, 4'h9, 0, 7'b0, 1'b1);
    run_cmd(2'd3, 1, 4'h0, 0, 7'b0, 1'b1);
    chk("ror1_example", usr_q, 4'hC);
    run_cmd(2'd3, 4, 4'h0, 0, 7'b0, 1'b1);
    chk("ror4_restore", usr_q, 4'hC);
    run_cmd(2'd1, 0, 4'h0, 0, 7'b0, 1'b1);
    run_cmd(2'd2, 7, 4'h3, 30, 7'b0, 1'b0);

    // Random commands.
    for (int n = 0; n < 40; n++) begin
      run_cmd(2'($urandom_range(3)), int'($urandom_range(7)), 4'($urandom_range(15)),
              int'($urandom_range(60)), 7'b0, 1'b0);
    end

    // Reset in the middle of a rotate aborts it.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'd3; cmd_count = 3'd7;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("abort_pre_select", usr_select, 1);
    rstN = 1'b0;
    @(negedge clk);
    chk("abort_select", usr_select, 0);
    chk("abort_done", done, 0);
    rstN = 1'b1;
    @(negedge clk);
    chk("abort_after_select", usr_select, 0);
    chk("abort_cmd_ready", cmd_ready, 1);
    $display("abort select=%0d cmd_ready=%0d", usr_select, cmd_ready);
    model_q = 4'h0;
    run_cmd(2'd0, 0, 4'h6, 0, 7'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
